simon_frame_loader: RTL and testbench

Receive-side framing stage between the UART byte receiver and the SIMON 32/64 core. Consumes the raw `rx_valid`/`rx_byte` stream, hunts for a sync byte, and parses a fixed 15-byte command frame: sync, command, 8 key bytes, 4 text bytes, XOR checksum. It assembles the 16-bit key and text words in the layout the core expects and presents them with a valid/ready handshake. Errors are reported by pulse and code, and a stalled frame is aborted on inter-byte timeout.

---
 rtl/simon_pkg.sv | 33 +++
 rtl/simon_frame_loader.sv | 167 ++++++++++++++++
 tb/tb_simon_frame_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simon_pkg
// Purpose  : Shared types and sizes for the SIMON 32/64 frame loader.
// Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam int KEY_BYTES  = 8;
    localparam int TEXT_BYTES = 4;
    localparam int KEY_WORDS  = KEY_BYTES / 2;
    localparam int TEXT_WORDS = TEXT_BYTES / 2;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_CMD  = 3'd1,
        ST_KEY  = 3'd2,
        ST_TEXT = 3'd3,
        ST_CSUM = 3'd4,
        ST_HOLD = 3'd5
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_BAD_CMD  = 2'b01,
        ERR_BAD_CSUM = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_t;

endpackage
`default_nettype wire

// File: rtl/simon_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : simon_frame_loader
// Purpose  : Hunts for a sync byte and parses a 15-byte command frame into
//            SIMON 32/64 key/text words behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module simon_frame_loader
    import simon_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  CMD_ENC        = 8'h45,
    parameter logic [7:0]  CMD_DEC        = 8'h44,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic                        frame_decrypt,
    output word_t [KEY_WORDS-1:0]       frame_key,
    output word_t [TEXT_WORDS-1:0]      frame_text,
    output logic                        err_pulse,
    output logic [1:0]                  err_code,
    output logic                        busy
);

    localparam int unsigned             c_TO_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TO_WIDTH-1:0]   c_TO_LAST  = c_TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]              c_KEY_LAST = 3'(KEY_BYTES - 1);
    localparam logic [2:0]              c_TEXT_LAST = 3'(TEXT_BYTES - 1);

    frame_state_t                   r_state;
    logic [c_TO_WIDTH-1:0]          r_timer;
    logic [2:0]                     r_idx;
    logic [7:0]                     r_csum;
    logic                           r_frame_valid;
    logic                           r_frame_decrypt;
    word_t [KEY_WORDS-1:0]          r_key;
    word_t [TEXT_WORDS-1:0]         r_text;
    logic                           r_err_pulse;
    err_code_t                      r_err_code;
    logic                           r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_HUNT;
            r_timer         <= '0;
            r_idx           <= '0;
            r_csum          <= '0;
            r_frame_valid   <= 1'b0;
            r_frame_decrypt <= 1'b0;
            r_key           <= '0;
            r_text          <= '0;
            r_err_pulse     <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_busy          <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (rx_valid && rx_byte == SYNC_BYTE) begin
                        r_state <= ST_CMD;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_timer <= '0;
                    end
                end

                ST_HOLD: begin
                    // A byte here has nowhere to go: flag the overrun, keep the frame.
                    if (rx_valid) begin
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                    end
                    if (frame_ready) begin
                        r_state       <= ST_HUNT;
                        r_busy        <= 1'b0;
                        r_frame_valid <= 1'b0;
                    end
                end

                default: begin
                    if (rx_valid) begin
                        r_timer <= '0;
                        case (r_state)
                            ST_CMD: begin
                                if (rx_byte == CMD_ENC || rx_byte == CMD_DEC) begin
                                    r_frame_decrypt <= (rx_byte == CMD_DEC);
                                    r_csum          <= rx_byte;
                                    r_state         <= ST_KEY;
                                    r_idx           <= '0;
                                end else begin
                                    r_state     <= ST_HUNT;
                                    r_busy      <= 1'b0;
                                    r_idx       <= '0;
                                    r_err_pulse <= 1'b1;
                                    r_err_code  <= ERR_BAD_CMD;
                                end
                            end

                            ST_KEY: begin
                                if (r_idx[0]) r_key[r_idx[2:1]][15:8] <= rx_byte;
                                else          r_key[r_idx[2:1]][7:0]  <= rx_byte;
                                r_csum <= r_csum ^ rx_byte;
                                if (r_idx == c_KEY_LAST) begin
                                    r_state <= ST_TEXT;
                                    r_idx   <= '0;
                                end else begin
                                    r_idx <= r_idx + 3'd1;
                                end
                            end

                            ST_TEXT: begin
                                if (r_idx[0]) r_text[r_idx[1]][15:8] <= rx_byte;
                                else          r_text[r_idx[1]][7:0]  <= rx_byte;
                                r_csum <= r_csum ^ rx_byte;
                                if (r_idx == c_TEXT_LAST) begin
                                    r_state <= ST_CSUM;
                                    r_idx   <= '0;
                                end else begin
                                    r_idx <= r_idx + 3'd1;
                                end
                            end

                            ST_CSUM: begin
                                r_idx <= '0;
                                if (rx_byte == r_csum) begin
                                    r_state       <= ST_HOLD;
                                    r_frame_valid <= 1'b1;
                                end else begin
                                    r_state     <= ST_HUNT;
                                    r_busy      <= 1'b0;
                                    r_err_pulse <= 1'b1;
                                    r_err_code  <= ERR_BAD_CSUM;
                                end
                            end

                            default: ;
                        endcase
                    end else if (r_timer == c_TO_LAST) begin
                        r_state     <= ST_HUNT;
                        r_busy      <= 1'b0;
                        r_idx       <= '0;
                        r_timer     <= '0;
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign frame_valid   = r_frame_valid;
    assign frame_decrypt = r_frame_decrypt;
    assign frame_key     = r_key;
    assign frame_text    = r_text;
    assign err_pulse     = r_err_pulse;
    assign err_code      = r_err_code;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_simon_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_frame_loader
// Purpose  : Directed bench for simon_frame_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_simon_frame_loader;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             frame_ready = 1'b0;
    logic             frame_valid;
    logic             frame_decrypt;
    logic [3:0][15:0] frame_key;
    logic [1:0][15:0] frame_text;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simon_frame_loader #(
        .SYNC_BYTE      (8'hA5),
        .CMD_ENC        (8'h45),
        .CMD_DEC        (8'h44),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_decrypt (frame_decrypt),
        .frame_key     (frame_key),
        .frame_text    (frame_text),
        .err_pulse     (err_pulse),
        .err_code      (err_code),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-position model: 0 hunting, 1 expecting command, 2..9 key bytes,
    // 10..13 text bytes, 14 checksum, 15 holding a frame.
    int         m_pos = 0;
    int         m_idle = 0;
    bit         m_started = 0;
    logic [7:0] m_cmd = 0;
    logic [7:0] m_kb [8];
    logic [7:0] m_tb [4];
    logic       m_dec = 0;
    logic       m_err = 0;
    logic [1:0] m_code = 0;

    always @(posedge clk) begin
        logic [7:0] x;
        m_err = 1'b0;
        if (rst) begin
            m_pos = 0; m_idle = 0; m_dec = 0; m_code = 0; m_cmd = 0;
            foreach (m_kb[i]) m_kb[i] = 8'h00;
            foreach (m_tb[i]) m_tb[i] = 8'h00;
            m_started = 1;
        end else if (m_pos == 0) begin
            if (rx_valid && rx_byte == 8'hA5) begin m_pos = 1; m_idle = 0; end
        end else if (m_pos == 15) begin
            if (rx_valid) begin m_err = 1'b1; m_code = 2'b11; end
            if (frame_ready) m_pos = 0;
        end else if (rx_valid) begin
            m_idle = 0;
            if (m_pos == 1) begin
                if (rx_byte == 8'h45 || rx_byte == 8'h44) begin
                    m_dec = (rx_byte == 8'h44); m_cmd = rx_byte; m_pos = 2;
                end else begin
                    m_err = 1'b1; m_code = 2'b01; m_pos = 0;
                end
            end else if (m_pos < 10) begin
                m_kb[m_pos-2] = rx_byte; m_pos++;
            end else if (m_pos < 14) begin
                m_tb[m_pos-10] = rx_byte; m_pos++;
            end else begin
                x = m_cmd;
                foreach (m_kb[i]) x ^= m_kb[i];
                foreach (m_tb[i]) x ^= m_tb[i];
                if (x == rx_byte) m_pos = 15;
                else begin m_err = 1'b1; m_code = 2'b10; m_pos = 0; end
            end
        end else begin
            m_idle++;
            if (m_idle == 16) begin m_err = 1'b1; m_code = 2'b11; m_pos = 0; end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("cyc_valid",   frame_valid,   (m_pos == 15));
            check("cyc_busy",    busy,          (m_pos != 0));
            check("cyc_err",     err_pulse,     m_err);
            check("cyc_code",    err_code,      m_code);
            check("cyc_decrypt", frame_decrypt, m_dec);
            check("cyc_key",     frame_key,
                  {m_kb[7], m_kb[6], m_kb[5], m_kb[4], m_kb[3], m_kb[2], m_kb[1], m_kb[0]});
            check("cyc_text",    frame_text, {m_tb[3], m_tb[2], m_tb[1], m_tb[0]});
        end
    end

    // Each call occupies one clock cycle; returns just after the sampling edge.
    task automatic drive(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] body [12], input bit corrupt);
        logic [7:0] cs;
        cs = cmd;
        drive(1'b1, 8'hA5);
        drive(1'b1, cmd);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, body[i]);
            cs ^= body[i];
        end
        drive(1'b1, corrupt ? ~cs : cs);
    endtask

    logic [7:0] f1    [15] = '{8'hA5, 8'h45, 8'h00, 8'h19, 8'h08, 8'h11, 8'h10, 8'h09,
                               8'h18, 8'h01, 8'h65, 8'h65, 8'h77, 8'h68, 8'h5A};
    logic [7:0] body2 [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                               8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] body3 [12] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'hDE, 8'hF0};

    initial begin
        idle(3);
        rst = 1'b0;
        check("reset_valid", frame_valid, 1'b0);
        check("reset_busy",  busy,        1'b0);
        check("reset_code",  err_code,    2'b00);
        check("reset_key",   frame_key,   64'h0);

        // Good encrypt frame with literal checksum 5A
        for (int i = 0; i < 14; i++) drive(1'b1, f1[i]);
        check("enc_valid_early", frame_valid, 1'b0);
        drive(1'b1, f1[14]);
        check("enc_valid_latency", frame_valid, 1'b1);
        check("enc_key",  frame_key,  64'h0118_0910_1108_1900);
        check("enc_text", frame_text, 32'h6877_6565);
        check("enc_decrypt", frame_decrypt, 1'b0);
        idle(20);
        check("enc_held", frame_valid, 1'b1);
        frame_ready = 1'b1;
        drive(1'b0, 8'h00);
        frame_ready = 1'b0;
        check("enc_accepted", frame_valid, 1'b0);
        check("enc_busy_after", busy, 1'b0);

        // Bad command, then sync value used as command
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h58);
        check("badcmd_pulse", err_pulse, 1'b1);
        check("badcmd_code",  err_code,  2'b01);
        check("badcmd_busy",  busy,      1'b0);
        drive(1'b0, 8'h00);
        check("badcmd_pulse_end", err_pulse, 1'b0);
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'hA5);
        check("synccmd_code", err_code, 2'b01);

        // Leading noise then a good frame, then an overrun in HOLD
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        send_frame(8'h45, body2, 1'b0);
        check("noise_valid", frame_valid, 1'b1);
        check("noise_key",   frame_key,   64'h0807_0605_0403_0201);
        check("noise_text",  frame_text,  32'hD4C3_B2A1);
        drive(1'b1, 8'h33);
        check("ovr_pulse", err_pulse,  1'b1);
        check("ovr_code",  err_code,   2'b11);
        check("ovr_valid", frame_valid, 1'b1);
        check("ovr_key",   frame_key,  64'h0807_0605_0403_0201);
        frame_ready = 1'b1;
        drive(1'b0, 8'h00);
        frame_ready = 1'b0;

        // Checksum failure on a decrypt frame
        send_frame(8'h44, body3, 1'b1);
        check("csum_pulse", err_pulse, 1'b1);
        check("csum_code",  err_code,  2'b10);
        check("csum_valid", frame_valid, 1'b0);
        idle(3);

        // Timeout after 16 idle cycles
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h44);
        idle(15);
        check("to_not_yet", busy, 1'b1);
        idle(1);
        check("to_pulse", err_pulse, 1'b1);
        check("to_code",  err_code,  2'b11);
        check("to_busy",  busy,      1'b0);

        // A byte at gap cycle 15 restarts the count
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h45);
        idle(14);
        drive(1'b1, 8'h00);
        idle(15);
        check("to_restart_busy", busy, 1'b1);
        idle(1);
        check("to_restart_pulse", err_pulse, 1'b1);

        // Reset in the middle of KEY
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h45);
        drive(1'b1, 8'h77);
        drive(1'b1, 8'h66);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        check("rst_busy",  busy,      1'b0);
        check("rst_pulse", err_pulse, 1'b0);
        check("rst_code",  err_code,  2'b00);
        check("rst_key",   frame_key, 64'h0);
        check("rst_dec",   frame_decrypt, 1'b0);
        rst = 1'b0;
        idle(2);

        // Good decrypt frame after everything
        send_frame(8'h44, body3, 1'b0);
        check("dec_valid",   frame_valid,   1'b1);
        check("dec_decrypt", frame_decrypt, 1'b1);
        check("dec_key",     frame_key,     64'h7856_3412_EFBE_ADDE);
        frame_ready = 1'b1;
        drive(1'b0, 8'h00);
        frame_ready = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
